// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result of a search-order scan: index of the winner and whether any was found.
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First requester at or after last+1 (wrapping); last itself has lowest priority.
  function automatic pick_t next_in_order(input logic [0:NUM_REQ-1] r,
                                          input logic [IDX_W-1:0]   last);
    pick_t            p;
    logic [IDX_W-1:0] c;
    p = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      c = last + IDX_W'(k);
      if (!p.found && r[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

  // One-hot decode of an owner index.
  function automatic logic [0:NUM_REQ-1] onehot(input logic [IDX_W-1:0] idx);
    logic [0:NUM_REQ-1] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mux4to1_w.sv
// WIDTH-bit 4-to-1 selector; slice i of W is W[i*WIDTH +: WIDTH].
module mux4to1_w #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [0:4*WIDTH-1] W,
  input  logic [1:0]         S,
  output logic [WIDTH-1:0]   f
);

  // Select the slice addressed by S.
  always_comb begin
    f = '0;
    case (S)
      2'd0:    f = W[0       +: WIDTH];
      2'd1:    f = W[WIDTH   +: WIDTH];
      2'd2:    f = W[2*WIDTH +: WIDTH];
      default: f = W[3*WIDTH +: WIDTH];
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering a shared 4-to-1 selector among four requesters.
// Optional hold timeout compiled in with `define ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [0:NUM_REQ-1]       req,
  input  logic [0:NUM_REQ*WIDTH-1] W,
  output logic [0:NUM_REQ-1]       gnt,
  output logic [IDX_W-1:0]         S,
  output logic                     valid,
  output logic [WIDTH-1:0]         f
);

  // Reject out-of-range hold limits at elaboration.
  if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold_max
    $fatal(1, "mux_rr_arbiter: HOLD_MAX must be in 2..15");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [0:NUM_REQ-1] gnt_d;
  logic [IDX_W-1:0]   s_d;
  logic [WIDTH-1:0]   mux_f;
  pick_t              pick_all;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
  logic [3:0] cnt_q, cnt_d;
  pick_t      pick_other;
`endif

  // State, pointer, grant and select registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      gnt     <= '0;
      S       <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      S       <= s_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and next-grant selection.
  always_comb begin
    logic             take;
    logic [IDX_W-1:0] take_idx;

    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt;
    s_d      = S;
    take     = 1'b0;
    take_idx = '0;
    pick_all = next_in_order(req, last_q);
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    pick_other = next_in_order(req & ~gnt, last_q);
`endif

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_all.found) begin
          take     = 1'b1;
          take_idx = pick_all.idx;
        end
      end
      GRANT: begin
        if (!req[S]) begin
          if (pick_all.found) begin
            take     = 1'b1;
            take_idx = pick_all.idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q == HOLD_LAST && pick_other.found) begin
            take     = 1'b1;
            take_idx = pick_other.idx;
          end else if (cnt_q != HOLD_LAST) begin
            cnt_d = cnt_q + 4'd1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (take) begin
      state_d = GRANT;
      gnt_d   = onehot(take_idx);
      s_d     = take_idx;
      last_d  = take_idx;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
  end

  assign valid = |gnt;

  mux4to1_w #(.WIDTH(WIDTH)) u_mux (
    .W (W),
    .S (S),
    .f (mux_f)
  );

  // Output is gated to zero whenever nobody owns the selector.
  assign f = valid ? mux_f : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter with a behavioural reference model.
module tb_mux_rr_arbiter;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned HOLD_MAX = 4;

  logic                 Clock = 1'b0;
  logic                 Reset;
  logic [0:3]           req;
  logic [0:4*WIDTH-1]   W;
  logic [0:3]           gnt;
  logic [1:0]           S;
  logic                 valid;
  logic [WIDTH-1:0]     f;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 when idle), pointer, select, cycles held.
  int m_owner, m_last, m_s, m_held;

  mux_rr_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .req   (req),
    .W     (W),
    .gnt   (gnt),
    .S     (S),
    .valid (valid),
    .f     (f)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [0:3] exp_gnt(input int o);
    logic [0:3] r;
    r = '0;
    if (o >= 0) r[o] = 1'b1;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] exp_f(input int o, input logic [0:4*WIDTH-1] w);
    if (o < 0) return '0;
    return w[o*WIDTH +: WIDTH];
  endfunction

  // First requester after 'last' in wrap-around order, skipping 'excl'.
  function automatic int search(input logic [0:3] r, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_last  = 3;
    m_s     = 0;
    m_held  = 0;
  endtask

  task automatic m_grant(input int c);
    m_owner = c;
    m_last  = c;
    m_s     = c;
    m_held  = 1;
  endtask

  task automatic m_update();
    int c;
    if (m_owner < 0 || !req[m_owner]) begin
      c = search(req, m_last, -1);
      if (c >= 0) m_grant(c);
      else m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      c = search(req, m_last, m_owner);
      if (m_held >= int'(HOLD_MAX) && c >= 0) m_grant(c);
      else m_held++;
`else
      m_held++;
`endif
    end
  endtask

  task automatic check_outputs();
    check_eq("gnt", 32'(gnt), 32'(exp_gnt(m_owner)));
    check_eq("S", 32'(S), 32'(m_s));
    check_eq("valid", 32'(valid), 32'(m_owner >= 0));
    check_eq("f", 32'(f), 32'(exp_f(m_owner, W)));
    check_eq("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic step();
    @(posedge Clock);
    m_update();
    @(negedge Clock);
    check_outputs();
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    m_reset();
  endtask

  initial begin
    int base;
    int exp_o;
    logic [0:3] r;

    Reset = 1'b1;
    req   = '0;
    W     = (4*WIDTH)'($urandom);
    m_reset();
    repeat (2) @(negedge Clock);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_S", 32'(S), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_f", 32'(f), 32'd0);
    Reset = 1'b0;

    // Requester 0 alone after reset.
    req = 4'b1000;
    step();
    check_eq("first_gnt", 32'(gnt), 32'(4'b1000));
    check_eq("first_S", 32'(S), 32'd0);
    check_eq("first_f", 32'(f), 32'(W[0 +: WIDTH]));
    req = '0;
    step();

    // All requesting, each owner releases after one cycle: strictly cyclic.
    base = (m_last + 1) % 4;
    for (int i = 0; i < 8; i++) begin
      req = 4'b1111 & ~exp_gnt(m_owner);
      step();
      check_eq("cyclic", 32'(S), 32'((base + i) % 4));
    end
    req = '0;
    step();

    // Owner 2 releases while 0 waits: direct handover, no idle bubble.
    req = 4'b0010;
    step();
    check_eq("own2", 32'(S), 32'd2);
    req = 4'b1010;
    step();
    check_eq("own2_hold", 32'(S), 32'd2);
    req = 4'b1000;
    step();
    check_eq("handover_S", 32'(S), 32'd0);
    check_eq("handover_valid", 32'(valid), 32'd1);

    // Two requesters held constantly.
    pulse_reset();
    req = 4'b1100;
    for (int i = 0; i < 20; i++) begin
      step();
`ifdef ARB_TIMEOUT_EN
      exp_o = (i / int'(HOLD_MAX)) % 2;
`else
      exp_o = 0;
`endif
      check_eq("hold_1100", 32'(S), 32'(exp_o));
    end
`ifdef ARB_TIMEOUT_EN
    pulse_reset();
    req = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("hold_1000", 32'(gnt), 32'(4'b1000));
    end
`endif

    // Asynchronous reset between edges while a grant is active.
    #2;
    Reset = 1'b1;
    #1;
    check_eq("async_gnt", 32'(gnt), 32'd0);
    check_eq("async_valid", 32'(valid), 32'd0);
    check_eq("async_f", 32'(f), 32'd0);
    check_eq("async_S", 32'(S), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    m_reset();
    req = 4'b0110;
    step();
    check_eq("post_rst_S", 32'(S), 32'd1);

    // Random traffic: owners drop their request at random, others toggle freely.
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == m_owner) r[b] = ($urandom_range(3) != 0);
        else              r[b] = 1'($urandom_range(1));
      end
      req = r;
      W   = (4*WIDTH)'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
